// File: rtl/rf_wb_arb.sv
// rf_wb_arb: arbitrates two write-back requesters onto the single register
// file write port, and keeps a scoreboard of registers still owed by the
// long-latency unit.
//
// Requester 0 is the in-order pipeline write-back and normally wins.
// Requester 1 is the long-latency unit (load / mul-div). It is forced to win
// once it has been refused STARVE_MAX times in a row.
//
// Ports
//   clk, rst               system clock (posedge); synchronous reset, active-low
//   p0_vld/rdy/addr/data   requester 0 write handshake
//   p1_vld/rdy/addr/data   requester 1 write handshake
//   RFWr, A3, WD           registered register file write port (1-cycle latency)
//   sb_set, sb_addr        mark a register as owed by requester 1
//   q_a1/q_a2, q_busy1/2   combinational hazard queries
//   sb_any                 any register pending
//
// Optional build macro WB_TRACE_EN: prints each register file write, and
// keeps the winning port number registered alongside A3/WD.

module rf_wb_arb #(
   parameter int STARVE_MAX = 4,
   parameter int SB_W       = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_vld,
   output logic        p0_rdy,
   input  logic [4:0]  p0_addr,
   input  logic [31:0] p0_data,
   input  logic        p1_vld,
   output logic        p1_rdy,
   input  logic [4:0]  p1_addr,
   input  logic [31:0] p1_data,
   output logic        RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD,
   input  logic        sb_set,
   input  logic [4:0]  sb_addr,
   input  logic [4:0]  q_a1,
   input  logic [4:0]  q_a2,
   output logic        q_busy1,
   output logic        q_busy2,
   output logic        sb_any
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]      starve_cnt;
   logic            force1;
   logic            acc0;
   logic            acc1;
   logic [SB_W-1:0] sb_q;
   logic [SB_W-1:0] sb_d;

   assign force1 = (starve_cnt >= STARVE_LIM);

   // Both ready lines are held low during reset so nothing can transfer.
   always_comb begin
      p0_rdy = 1'b0;
      p1_rdy = 1'b0;
      if (rst) begin
         if (force1) begin
            p1_rdy = 1'b1;
            p0_rdy = !p1_vld;
         end else begin
            p0_rdy = 1'b1;
            p1_rdy = !p0_vld;
         end
      end
   end

   assign acc0 = p0_vld && p0_rdy;
   assign acc1 = p1_vld && p1_rdy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (acc1) begin
         starve_cnt <= '0;
      end else if (p1_vld && !p1_rdy && (starve_cnt != 4'hF)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // A write to x0 is still accepted; only the write enable is suppressed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         RFWr <= 1'b0;
         A3   <= '0;
         WD   <= '0;
      end else if (acc0) begin
         RFWr <= (p0_addr != 5'd0);
         A3   <= p0_addr;
         WD   <= p0_data;
      end else if (acc1) begin
         RFWr <= (p1_addr != 5'd0);
         A3   <= p1_addr;
         WD   <= p1_data;
      end else begin
         RFWr <= 1'b0;
      end
   end

   // Set is applied after clear so a same-cycle set to the same register wins.
   // Bit 0 can never be set.
   always_comb begin
      sb_d = sb_q;
      for (int i = 0; i < SB_W; i++) begin
         if (acc1 && (p1_addr == 5'(i)))
            sb_d[i] = 1'b0;
         if (sb_set && (sb_addr == 5'(i)) && (i != 0))
            sb_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) sb_q <= '0;
      else      sb_q <= sb_d;
   end

   assign q_busy1 = (q_a1 != 5'd0) && sb_q[q_a1];
   assign q_busy2 = (q_a2 != 5'd0) && sb_q[q_a2];
   assign sb_any  = |sb_q;

`ifdef WB_TRACE_EN
   logic wb_port;

   always_ff @(posedge clk) begin
      if (!rst)      wb_port <= 1'b0;
      else if (acc0) wb_port <= 1'b0;
      else if (acc1) wb_port <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst && RFWr)
         $display("wb p%0d r[%0d] = 0x%08h", wb_port, A3, WD);
   end
`endif

endmodule
